// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// even/odd parity bit, one stop bit; each bit lasts PRESCALE clock cycles.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nx;
  logic [5:0]            cnt, cnt_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [DATA_WIDTH-1:0] data_q;
  logic [5:0]            prescale_q;
  logic                  par_en_q, par_typ_q;
  logic                  load;
  logic                  tx_nx, busy_nx;
  logic                  bit_done;

  // Bit-cycle counter reload value; a prescale of 0 behaves like 1.
  function automatic logic [5:0] reload(input logic [5:0] ps);
    return (ps == 6'd0) ? 6'd0 : ps - 6'd1;
  endfunction

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign bit_done = (cnt == 6'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      data_q     <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      TX_OUT     <= 1'b1;
      BUSY       <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      TX_OUT <= tx_nx;
      BUSY   <= busy_nx;
      if (load) begin
        data_q     <= P_DATA;
        prescale_q <= PRESCALE;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
      end
    end
  end

  // Next-state logic; TX_OUT/BUSY are computed one edge ahead so both come straight from flops.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    load     = 1'b0;
    tx_nx    = TX_OUT;
    busy_nx  = BUSY;
    case (state)
      IDLE: begin
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
        if (DATA_VALID) begin
          load     = 1'b1;
          state_nx = START;
          cnt_nx   = reload(PRESCALE);
          idx_nx   = '0;
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_nx = DATA;
          cnt_nx   = reload(prescale_q);
          idx_nx   = '0;
          tx_nx    = data_q[0];
        end else begin
          cnt_nx = cnt - 6'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_nx = reload(prescale_q);
          if (idx == LAST_IDX) begin
            if (par_en_q) begin
              state_nx = PARITY;
              tx_nx    = parity_bit(data_q, par_typ_q);
            end else begin
              state_nx = STOP;
              tx_nx    = 1'b1;
            end
          end else begin
            idx_nx = idx + IDX_W'(1);
            tx_nx  = data_q[idx + IDX_W'(1)];
          end
        end else begin
          cnt_nx = cnt - 6'd1;
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_nx = STOP;
          cnt_nx   = reload(prescale_q);
          tx_nx    = 1'b1;
        end else begin
          cnt_nx = cnt - 6'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_nx = IDLE;
          tx_nx    = 1'b1;
          busy_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - 6'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule
